// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp: multi-read-port register file with write bypass, pending scoreboard and
// a post-reset sequencer that zeroes one entry per cycle before the ports go live.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int REG_SIZE = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1
) (
  input  logic                    clk_a,
  input  logic                    rst_a,
  output logic                    ready,
  input  logic                    wen_a,
  input  logic [REG_SIZE-1:0]     addr_a,
  input  logic [XLEN-1:0]         in_a,
  input  logic                    issue_en,
  input  logic [REG_SIZE-1:0]     issue_addr,
  input  logic [NRD*REG_SIZE-1:0] addr_b,
  output logic [NRD*XLEN-1:0]     out_b,
  output logic [NRD-1:0]          busy_b
);

  localparam int NREGS = 2**REG_SIZE;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [REG_SIZE-1:0] init_ptr_q, init_ptr_d;
  logic [NREGS-1:0]    pend_q, pend_d;
  logic [XLEN-1:0]     reg_data_q [NREGS];

  logic w_wr_valid;
  logic w_issue_valid;

  assign ready         = (state_q == S_RUN);
  assign w_wr_valid    = ready && wen_a && (addr_a != '0);
  assign w_issue_valid = ready && issue_en && (issue_addr != '0);

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      pend_q     <= pend_d;
    end
  end

  // Issue is applied after the write clear so a same-cycle issue leaves the entry pending.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    pend_d     = pend_q;
    case (state_q)
      S_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == {REG_SIZE{1'b1}}) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (w_wr_valid) begin
          pend_d[addr_a] = 1'b0;
        end
        if (w_issue_valid) begin
          pend_d[issue_addr] = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Storage has no reset of its own; the init sequencer zeroes it after every reset.
  always_ff @(posedge clk_a) begin
    if (!rst_a) begin
      if (state_q == S_INIT) begin
        reg_data_q[init_ptr_q] <= '0;
      end else if (w_wr_valid) begin
        reg_data_q[addr_a] <= in_a;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [REG_SIZE-1:0] rd_addr;
    logic [XLEN-1:0]     rd_data;
    logic                rd_busy;

    assign rd_addr = addr_b[k*REG_SIZE +: REG_SIZE];

    always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (ready && (rd_addr != '0)) begin
        if ((BYPASS != 0) && wen_a && (addr_a == rd_addr)) begin
          rd_data = in_a;
        end else begin
          rd_data = reg_data_q[rd_addr];
          rd_busy = pend_q[rd_addr];
        end
      end
    end

    assign out_b[k*XLEN +: XLEN] = rd_data;
    assign busy_b[k]             = rd_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_mp;

  localparam int XLEN     = 32;
  localparam int REG_SIZE = 5;
  localparam int NRD      = 2;
  localparam int NREGS    = 32;

  logic                    clk_a;
  logic                    rst_a;
  logic                    wen_a;
  logic [REG_SIZE-1:0]     addr_a;
  logic [XLEN-1:0]         in_a;
  logic                    issue_en;
  logic [REG_SIZE-1:0]     issue_addr;
  logic [NRD*REG_SIZE-1:0] addr_b;

  logic                    ready, ready0;
  logic [NRD*XLEN-1:0]     out_b, out_b0;
  logic [NRD-1:0]          busy_b, busy_b0;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.XLEN(XLEN), .REG_SIZE(REG_SIZE), .NRD(NRD), .BYPASS(1)) dut (
    .clk_a(clk_a), .rst_a(rst_a), .ready(ready),
    .wen_a(wen_a), .addr_a(addr_a), .in_a(in_a),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .addr_b(addr_b), .out_b(out_b), .busy_b(busy_b)
  );

  regfile_mp #(.XLEN(XLEN), .REG_SIZE(REG_SIZE), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk_a(clk_a), .rst_a(rst_a), .ready(ready0),
    .wen_a(wen_a), .addr_a(addr_a), .in_a(in_a),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .addr_b(addr_b), .out_b(out_b0), .busy_b(busy_b0)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic set_rd(input int p0, input int p1);
    addr_b[0 +: REG_SIZE]        = REG_SIZE'(p0);
    addr_b[REG_SIZE +: REG_SIZE] = REG_SIZE'(p1);
  endtask

  task automatic idle();
    wen_a = 1'b0; addr_a = '0; in_a = '0;
    issue_en = 1'b0; issue_addr = '0;
  endtask

  // Reset pulse then the full init window; optionally write/issue x3 while still in INIT.
  task automatic run_init(input bit inject);
    idle();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    set_rd(5, 9);
    for (int i = 1; i <= NREGS; i++) begin
      if (inject && i == 10) begin
        wen_a = 1'b1; addr_a = 5'd3; in_a = 32'h0000_ABCD;
        issue_en = 1'b1; issue_addr = 5'd3;
      end
      if (inject && i == 11) idle();
      tick();
      checks++;
      if (ready !== (i == NREGS)) begin
        errors++;
        $display("FAIL init_ready cycle %0d: got %b expected %b", i, ready, (i == NREGS));
      end
      if (i < NREGS) begin
        checks++;
        if (out_b !== '0 || busy_b !== '0) begin
          errors++;
          $display("FAIL init_reads cycle %0d: got out=%h busy=%b expected 0/0", i, out_b, busy_b);
        end
      end
    end
    checks++;
    if (ready0 !== 1'b1) begin
      errors++;
      $display("FAIL init_ready_nb: got %b expected 1", ready0);
    end
    #1;
    checks++;
    if (out_b !== '0 || busy_b !== '0) begin
      errors++;
      $display("FAIL post_init_x5_x9: got out=%h busy=%b expected 0/0", out_b, busy_b);
    end
  endtask

  task automatic test_reset();
    run_init(1'b0);
    set_rd(1, 31);
    #1;
    checks++;
    if (out_b !== '0 || busy_b !== '0) begin
      errors++;
      $display("FAIL reset_x1_x31: got out=%h busy=%b expected 0/0", out_b, busy_b);
    end
  endtask

  task automatic test_write();
    set_rd(0, 0);
    wen_a = 1'b1; addr_a = 5'd5; in_a = 32'hDEAD_BEEF;
    tick();
    idle();
    set_rd(5, 0);
    #1;
    checks++;
    if (out_b[0 +: XLEN] !== 32'hDEAD_BEEF || busy_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_x5: got %h busy=%b expected deadbeef busy=0", out_b[0 +: XLEN], busy_b[0]);
    end
    checks++;
    if (out_b0[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_x5_nb: got %h expected deadbeef", out_b0[0 +: XLEN]);
    end
  endtask

  task automatic test_bypass();
    set_rd(0, 7);
    wen_a = 1'b1; addr_a = 5'd7; in_a = 32'h0000_1234;
    #1;
    checks++;
    if (out_b[XLEN +: XLEN] !== 32'h0000_1234) begin
      errors++;
      $display("FAIL bypass_on: got %h expected 00001234", out_b[XLEN +: XLEN]);
    end
    checks++;
    if (out_b0[XLEN +: XLEN] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_off: got %h expected 00000000", out_b0[XLEN +: XLEN]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (out_b[XLEN +: XLEN] !== 32'h0000_1234 || out_b0[XLEN +: XLEN] !== 32'h0000_1234) begin
      errors++;
      $display("FAIL bypass_stored: got %h/%h expected 00001234", out_b[XLEN +: XLEN], out_b0[XLEN +: XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    set_rd(9, 9);
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (busy_b !== 2'b11 || busy_b0 !== 2'b11 || out_b !== '0) begin
      errors++;
      $display("FAIL issue_busy: got busy=%b/%b out=%h expected 11/11 0", busy_b, busy_b0, out_b);
    end
    wen_a = 1'b1; addr_a = 5'd9; in_a = 32'h0000_0055;
    #1;
    checks++;
    if (busy_b !== 2'b00 || out_b !== {2{32'h0000_0055}}) begin
      errors++;
      $display("FAIL wb_bypass_busy: got busy=%b out=%h expected 00 55/55", busy_b, out_b);
    end
    checks++;
    if (busy_b0 !== 2'b11 || out_b0 !== '0) begin
      errors++;
      $display("FAIL wb_nobypass_busy: got busy=%b out=%h expected 11 0", busy_b0, out_b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_b !== 2'b00 || busy_b0 !== 2'b00 || out_b0 !== {2{32'h0000_0055}}) begin
      errors++;
      $display("FAIL wb_cleared: got busy=%b/%b out=%h expected 00/00 55/55", busy_b, busy_b0, out_b0);
    end
    wen_a = 1'b1; addr_a = 5'd9; in_a = 32'h0000_0077;
    issue_en = 1'b1; issue_addr = 5'd9;
    tick();
    idle();
    #1;
    checks++;
    if (out_b !== {2{32'h0000_0077}} || busy_b !== 2'b11 || busy_b0 !== 2'b11) begin
      errors++;
      $display("FAIL wr_issue_same: got out=%h busy=%b/%b expected 77/77 11/11", out_b, busy_b, busy_b0);
    end
  endtask

  task automatic test_x0();
    set_rd(0, 0);
    wen_a = 1'b1; addr_a = 5'd0; in_a = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 5'd0;
    #1;
    checks++;
    if (out_b !== '0 || busy_b !== '0) begin
      errors++;
      $display("FAIL x0_same_cycle: got out=%h busy=%b expected 0/0", out_b, busy_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (out_b !== '0 || busy_b !== '0 || out_b0 !== '0 || busy_b0 !== '0) begin
      errors++;
      $display("FAIL x0_after: got out=%h busy=%b expected 0/0", out_b, busy_b);
    end
    set_rd(5, 9);
    #1;
    checks++;
    if (out_b !== {32'h0000_0077, 32'hDEAD_BEEF} || busy_b !== 2'b10) begin
      errors++;
      $display("FAIL x0_no_side_effect: got out=%h busy=%b expected 00000077deadbeef 10", out_b, busy_b);
    end
  endtask

  task automatic test_reset_mid();
    // Reset while x9 is pending, with a write presented in the reset cycle.
    rst_a = 1'b1;
    wen_a = 1'b1; addr_a = 5'd5; in_a = 32'h1111_1111;
    tick();
    rst_a = 1'b0;
    idle();
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (ready !== 1'b0 || out_b !== '0 || busy_b !== '0) begin
        errors++;
        $display("FAIL mid_init_partial cycle %0d: got ready=%b out=%h busy=%b expected 0", i, ready, out_b, busy_b);
      end
    end
    run_init(1'b1);
    set_rd(3, 9);
    #1;
    checks++;
    if (out_b !== '0 || busy_b !== '0 || busy_b0 !== '0) begin
      errors++;
      $display("FAIL after_reinit_x3_x9: got out=%h busy=%b/%b expected 0 00/00", out_b, busy_b, busy_b0);
    end
    set_rd(5, 7);
    #1;
    checks++;
    if (out_b !== '0 || out_b0 !== '0) begin
      errors++;
      $display("FAIL after_reinit_x5_x7: got %h/%h expected 0", out_b, out_b0);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    addr_b = '0;
    idle();
    tick();
    test_reset();
    test_write();
    test_bypass();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
